// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame accumulator.
//   state_e  : controller states (ACCUM collects words, HOLD presents a result)
//   PAR_EVEN : mode value for even parity
//   PAR_ODD  : mode value for odd parity
package parity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/word_parity.sv
// Combinational XOR-reduction of one data word (a WIDTH-input XOR gate).
// Ports:
//   data_i   [WIDTH-1:0] : word to reduce
//   parity_o             : XOR of all bits of data_i
module word_parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_accumulator.sv
// Streaming parity generator/checker. Accumulates the XOR parity of WIDTH-bit
// words over a frame of up to FRAME_LEN words and emits one registered result
// per frame.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low; ready never depends combinationally on the same side's valid.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : input word handshake
//   in_data [WIDTH]    : data word
//   in_last            : accepted word ends the frame early
//   in_odd             : parity mode, sampled with the first word of a frame
//   in_exp             : expected parity, sampled with the terminating word
//   out_valid/out_ready: result handshake
//   out_parity         : computed frame parity
//   out_error          : out_parity differs from the expected bit
//   out_count          : number of words in the frame (1..FRAME_LEN)
module parity_frame_accumulator
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    input  logic                           in_odd,
    input  logic                           in_exp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_parity,
    output logic                           out_error,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_count
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    state_e          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            out_valid_q, out_valid_d;
    logic            out_parity_q, out_parity_d;
    logic            out_error_q, out_error_d;
    logic [CW-1:0]   out_count_q, out_count_d;

    logic            word_par;
    logic            accept;
    logic            mode_eff;
    logic [CW-1:0]   cnt_plus;
    logic            term;
    logic            result_par;

    word_parity #(.WIDTH(WIDTH)) u_word_parity (
        .data_i   (in_data),
        .parity_o (word_par)
    );

    // In HOLD the input side only moves when the result is being taken in the
    // same cycle, so a new frame can start without a bubble.
    assign in_ready = (state_q == ACCUM) ? 1'b1 : out_ready;
    assign accept   = in_valid && in_ready;

    // Count and accumulator are cleared at every termination, so a zero count
    // marks the first word of a frame in both states.
    assign mode_eff   = (cnt_q == '0) ? in_odd : mode_q;
    assign cnt_plus   = cnt_q + CW'(1);
    assign term       = in_last || (cnt_plus == CW'(FRAME_LEN));
    assign result_par = acc_q ^ word_par ^ mode_eff;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_error_d  = out_error_q;
        out_count_d  = out_count_q;

        // Result consumed: fall back to ACCUM unless a terminating word below
        // immediately reloads the result registers.
        if (state_q == HOLD && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        if (accept) begin
            if (term) begin
                out_valid_d  = 1'b1;
                out_parity_d = result_par;
                out_error_d  = result_par ^ in_exp;
                out_count_d  = cnt_plus;
                acc_d        = 1'b0;
                cnt_d        = '0;
                state_d      = HOLD;
            end else begin
                acc_d  = acc_q ^ word_par;
                cnt_d  = cnt_plus;
                mode_d = mode_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            mode_q       <= PAR_EVEN;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_error_q  <= 1'b0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_error_q  <= out_error_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_error  = out_error_q;
    assign out_count  = out_count_q;

endmodule

// File: tb/tb_parity_frame_accumulator.sv
module tb_parity_frame_accumulator;

    logic       clk;
    logic       rst;

    // DUT with FRAME_LEN=4
    logic       in_valid, in_ready, in_last, in_odd, in_exp;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_parity, out_error;
    logic [2:0] out_count;

    // DUT with FRAME_LEN=1
    logic       b_in_valid, b_in_ready, b_in_last, b_in_odd, b_in_exp;
    logic [7:0] b_in_data;
    logic       b_out_valid, b_out_ready, b_out_parity, b_out_error;
    logic [0:0] b_out_count;

    int checks;
    int errors;

    parity_frame_accumulator #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_odd     (in_odd),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_error  (out_error),
        .out_count  (out_count)
    );

    parity_frame_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .in_last    (b_in_last),
        .in_odd     (b_in_odd),
        .in_exp     (b_in_exp),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_parity (b_out_parity),
        .out_error  (b_out_error),
        .out_count  (b_out_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       odd;
        logic       exp;
        logic       ordy;
        logic       x_ir;      // in_ready before the edge
        logic       x_ov;      // out_valid after the edge
        logic       chk_res;   // compare result fields after the edge
        logic       x_par;
        logic       x_err;
        logic [2:0] x_cnt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic vld, input logic [7:0] data,
                                input logic last, input logic odd,
                                input logic exp, input logic ordy,
                                input logic x_ir, input logic x_ov,
                                input logic chk_res, input logic x_par,
                                input logic x_err, input logic [2:0] x_cnt);
        vec_t v;
        v.vld = vld; v.data = data; v.last = last; v.odd = odd;
        v.exp = exp; v.ordy = ordy; v.x_ir = x_ir; v.x_ov = x_ov;
        v.chk_res = chk_res; v.x_par = x_par; v.x_err = x_err; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] data, input logic last,
                         input logic odd, input logic exp, input logic ordy);
        in_valid  = vld;
        in_data   = data;
        in_last   = last;
        in_odd    = odd;
        in_exp    = exp;
        out_ready = ordy;
    endtask

    // One cycle: inputs set just after an edge, in_ready checked before the
    // next edge, outputs checked 1 time unit after it.
    task automatic step_check(input string name, input vec_t v);
        drive(v.vld, v.data, v.last, v.odd, v.exp, v.ordy);
        #1;
        check({name, ".in_ready"}, 8'(in_ready), 8'(v.x_ir));
        @(posedge clk);
        #1;
        check({name, ".out_valid"}, 8'(out_valid), 8'(v.x_ov));
        if (v.chk_res) begin
            check({name, ".out_parity"}, 8'(out_parity), 8'(v.x_par));
            check({name, ".out_error"}, 8'(out_error), 8'(v.x_err));
            check({name, ".out_count"}, 8'(out_count), 8'(v.x_cnt));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0;
        b_in_odd = 1'b0; b_in_exp = 1'b0; b_out_ready = 1'b0;

        //              vld data  last odd exp ordy  ir ov chk par err cnt
        // full even frame: parities 1,0,1,0 -> 0
        vecs[0]  = mk(1, 8'h01, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        vecs[1]  = mk(1, 8'h03, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        vecs[2]  = mk(1, 8'h07, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        vecs[3]  = mk(1, 8'h0F, 0, 0, 0, 1,  1, 1, 1, 0, 0, 3'd4);
        vecs[4]  = mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        // early end, odd mode: 1 ^ 0 ^ 1 = 0, exp 1 -> error
        vecs[5]  = mk(1, 8'h01, 0, 1, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        vecs[6]  = mk(1, 8'h00, 1, 0, 1, 0,  1, 1, 1, 0, 1, 3'd2);
        // backpressure: result held, word waiting
        vecs[7]  = mk(1, 8'h03, 0, 0, 0, 0,  0, 1, 1, 0, 1, 3'd2);
        vecs[8]  = mk(1, 8'h03, 0, 0, 0, 0,  0, 1, 1, 0, 1, 3'd2);
        vecs[9]  = mk(1, 8'h03, 0, 0, 0, 0,  0, 1, 1, 0, 1, 3'd2);
        // consume and accept word 1 (parity 0, even) in the same cycle
        vecs[10] = mk(1, 8'h03, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        // word 2 terminates: 0 ^ 1 ^ 0 = 1, exp 0 -> error, count 2
        vecs[11] = mk(1, 8'h01, 1, 1, 0, 0,  1, 1, 1, 1, 1, 3'd2);
        vecs[12] = mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);
        // single-word frames back to back via in_last
        vecs[13] = mk(1, 8'h01, 1, 1, 1, 1,  1, 1, 1, 0, 1, 3'd1);
        vecs[14] = mk(1, 8'h07, 1, 0, 0, 1,  1, 1, 1, 1, 1, 3'd1);
        vecs[15] = mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'd0);

        // reset: asserted asynchronously between edges
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst.out_valid", 8'(out_valid), 8'h00);
        check("rst.out_parity", 8'(out_parity), 8'h00);
        check("rst.out_error", 8'(out_error), 8'h00);
        check("rst.out_count", 8'(out_count), 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst.in_ready", 8'(in_ready), 8'h01);
        check("rst.b_in_ready", 8'(b_in_ready), 8'h01);

        for (int i = 0; i < 16; i++) begin
            step_check($sformatf("vec%0d", i), vecs[i]);
        end

        // async reset clears a pending result immediately
        step_check("pre_rst", mk(1, 8'hFF, 1, 1, 1, 0, 1, 1, 1, 1, 0, 3'd1));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 8'(out_valid), 8'h00);
        check("async_rst.out_parity", 8'(out_parity), 8'h00);
        check("async_rst.out_count", 8'(out_count), 8'h00);
        check("async_rst.in_ready", 8'(in_ready), 8'h01);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // reset mid-frame: partial frame (acc=1, count=2) must be discarded
        step_check("mid0", mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0));
        step_check("mid1", mk(1, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // new frame parities 1,1,1,0 -> 1, even, exp 1 -> no error
        step_check("new0", mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0));
        step_check("new1", mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0));
        step_check("new2", mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0));
        step_check("new3", mk(1, 8'h00, 0, 0, 1, 1, 1, 1, 1, 1, 0, 3'd4));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // FRAME_LEN=1: back-to-back frames without a bubble
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hFF;
        b_in_odd    = 1'b0;
        b_in_exp    = 1'b0;
        #1;
        check("b2b0.in_ready", 8'(b_in_ready), 8'h01);
        @(posedge clk);
        #1;
        check("b2b0.out_valid", 8'(b_out_valid), 8'h01);
        check("b2b0.out_parity", 8'(b_out_parity), 8'h00);
        check("b2b0.out_error", 8'(b_out_error), 8'h00);
        check("b2b0.out_count", 8'(b_out_count), 8'h01);
        b_in_data = 8'h80;
        #1;
        check("b2b1.in_ready", 8'(b_in_ready), 8'h01);
        @(posedge clk);
        #1;
        check("b2b1.out_valid", 8'(b_out_valid), 8'h01);
        check("b2b1.out_parity", 8'(b_out_parity), 8'h01);
        check("b2b1.out_error", 8'(b_out_error), 8'h01);
        check("b2b1.out_count", 8'(b_out_count), 8'h01);
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_end.out_valid", 8'(b_out_valid), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
